// File: rtl/fifo_chk_pkg.sv
// Shared types for the FIFO checker: observed-signal indices and checker FSM states.
package fifo_chk_pkg;

    typedef enum logic [2:0] {
        SIG_WR_ACK      = 3'd0,
        SIG_FULL        = 3'd1,
        SIG_EMPTY       = 3'd2,
        SIG_ALMOSTFULL  = 3'd3,
        SIG_ALMOSTEMPTY = 3'd4,
        SIG_OVERFLOW    = 3'd5,
        SIG_UNDERFLOW   = 3'd6,
        SIG_DATA_OUT    = 3'd7
    } sig_idx_e;

    localparam int NUM_SIGS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } chk_state_e;

endpackage

// File: rtl/fifo_ref_model.sv
// Cycle-accurate shadow of the observed FIFO; driven only by wr_en/rd_en/data_in.
// 'hold' freezes every piece of state (used when the checker halts).
module fifo_ref_model #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic                  exp_full,
    output logic                  exp_empty,
    output logic                  exp_almostfull,
    output logic                  exp_almostempty,
    output logic                  exp_wr_ack,
    output logic                  exp_overflow,
    output logic                  exp_underflow,
    output logic [FIFO_WIDTH-1:0] exp_data_out
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  ONE_C    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    assign exp_full        = (count_r == DEPTH_C);
    assign exp_empty       = (count_r == '0);
    assign exp_almostfull  = (count_r == (DEPTH_C - ONE_C));
    assign exp_almostempty = (count_r == ONE_C);

    assign wr_acc_s = wr_en && !exp_full;
    assign rd_acc_s = rd_en && !exp_empty;

    // Shadow storage; contents are only observed after a write has filled them.
    always_ff @(posedge clk) begin
        if (!hold && wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and the one-cycle-late output predictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
            exp_data_out  <= '0;
        end else if (!hold) begin
            exp_wr_ack    <= wr_acc_s;
            exp_overflow  <= wr_en && exp_full;
            exp_underflow <= rd_en && exp_empty;
            if (wr_acc_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r     <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PTR_W'(1);
                exp_data_out <= mem_r[rd_ptr_r];
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_checker.sv
// Passive FIFO checker: shadow model, per-signal compare, saturating counters, readout.
// Optional stop-on-first-error behaviour is compiled in with FIFO_CHK_HALT_EN.
import fifo_chk_pkg::*;

module fifo_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  chk_en,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    input  logic [2:0]            sel,
    output logic [CNT_W-1:0]      correct_cnt,
    output logic [CNT_W-1:0]      error_cnt,
    output logic [7:0]            err_sticky,
    output logic                  any_err,
    output logic                  halted
);
    logic                  exp_full, exp_empty, exp_almostfull, exp_almostempty;
    logic                  exp_wr_ack, exp_overflow, exp_underflow;
    logic [FIFO_WIDTH-1:0] exp_data_out;
    logic [NUM_SIGS-1:0]   mis_s;
    logic [NUM_SIGS-1:0]   sticky_r;
    logic [CNT_W-1:0]      correct_r [NUM_SIGS];
    logic [CNT_W-1:0]      error_r   [NUM_SIGS];
    chk_state_e            state_r;
    logic                  count_en_s;
    logic                  freeze_s;
    logic                  halt_trip_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    fifo_ref_model #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ref (
        .clk             (clk),
        .rst_n           (rst_n),
        .hold            (freeze_s),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .data_in         (data_in),
        .exp_full        (exp_full),
        .exp_empty       (exp_empty),
        .exp_almostfull  (exp_almostfull),
        .exp_almostempty (exp_almostempty),
        .exp_wr_ack      (exp_wr_ack),
        .exp_overflow    (exp_overflow),
        .exp_underflow   (exp_underflow),
        .exp_data_out    (exp_data_out)
    );

    assign count_en_s = (state_r == ST_RUN) && chk_en;

`ifdef FIFO_CHK_HALT_EN
    logic halted_r;
    assign halt_trip_s = count_en_s && (|mis_s);
    assign freeze_s    = (state_r == ST_HALT) || halt_trip_s;
    assign halted      = halted_r;

    // Halt flag: set by the first counted mismatch, cleared only by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else if (clr) begin
            halted_r <= 1'b0;
        end else if (halt_trip_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end
`else
    assign halt_trip_s = 1'b0;
    assign freeze_s    = 1'b0;
    assign halted      = 1'b0;
`endif

    // Per-signal compare of the observed FIFO against the shadow model.
    always_comb begin
        mis_s                  = '0;
        mis_s[SIG_WR_ACK]      = (wr_ack      != exp_wr_ack);
        mis_s[SIG_FULL]        = (full        != exp_full);
        mis_s[SIG_EMPTY]       = (empty       != exp_empty);
        mis_s[SIG_ALMOSTFULL]  = (almostfull  != exp_almostfull);
        mis_s[SIG_ALMOSTEMPTY] = (almostempty != exp_almostempty);
        mis_s[SIG_OVERFLOW]    = (overflow    != exp_overflow);
        mis_s[SIG_UNDERFLOW]   = (underflow   != exp_underflow);
        mis_s[SIG_DATA_OUT]    = (data_out    != exp_data_out);
    end

    // Checker FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= chk_en ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (!chk_en) begin
                        state_r <= ST_IDLE;
                    end else if (halt_trip_s) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Saturating correct/error counters and sticky error bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= '0;
            for (int i = 0; i < NUM_SIGS; i++) begin
                correct_r[i] <= '0;
                error_r[i]   <= '0;
            end
        end else if (clr) begin
            sticky_r <= '0;
            for (int i = 0; i < NUM_SIGS; i++) begin
                correct_r[i] <= '0;
                error_r[i]   <= '0;
            end
        end else if (count_en_s) begin
            for (int i = 0; i < NUM_SIGS; i++) begin
                if (mis_s[i]) begin
                    error_r[i]  <= sat_inc(error_r[i]);
                    sticky_r[i] <= 1'b1;
                end else begin
                    correct_r[i] <= sat_inc(correct_r[i]);
                end
            end
        end
    end

    // Counter readout for the selected signal.
    always_comb begin
        if (int'(sel) < NUM_SIGS) begin
            correct_cnt = correct_r[sel];
            error_cnt   = error_r[sel];
        end else begin
            correct_cnt = '0;
            error_cnt   = '0;
        end
    end

    assign err_sticky = sticky_r;
    assign any_err    = |sticky_r;

endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench: a behavioural FIFO feeds fifo_checker; checker counters and flags are compared.
`timescale 1ns/1ps
module tb_fifo_checker;
    import fifo_chk_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n, chk_en, clr, wr_en, rd_en;
    logic [W-1:0]  data_in, data_out;
    logic          wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [2:0]    sel;
    logic [CW-1:0] correct_cnt, error_cnt;
    logic [7:0]    err_sticky;
    logic          any_err, halted;
    logic          bug_full0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .sel(sel), .correct_cnt(correct_cnt), .error_cnt(error_cnt),
        .err_sticky(err_sticky), .any_err(any_err), .halted(halted)
    );

    // Observed FIFO (behavioural), with an optional full-stuck-at-0 fault.
    logic [W-1:0] f_mem [D];
    int f_cnt, f_wp, f_rp;
    assign full        = (f_cnt == D) && !bug_full0;
    assign empty       = (f_cnt == 0);
    assign almostfull  = (f_cnt == D - 1);
    assign almostempty = (f_cnt == 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt <= 0; f_wp <= 0; f_rp <= 0;
            wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0; data_out <= '0;
        end else begin
            wr_ack    <= wr_en && (f_cnt < D);
            overflow  <= wr_en && (f_cnt == D);
            underflow <= rd_en && (f_cnt == 0);
            if (wr_en && f_cnt < D) begin
                f_mem[f_wp] <= data_in;
                f_wp <= (f_wp + 1) % D;
            end
            if (rd_en && f_cnt > 0) begin
                data_out <= f_mem[f_rp];
                f_rp <= (f_rp + 1) % D;
            end
            f_cnt <= f_cnt + ((wr_en && f_cnt < D) ? 1 : 0) - ((rd_en && f_cnt > 0) ? 1 : 0);
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] base;
        int          ncyc;
        int          exp_corr;
        int          exp_err;
        logic [7:0]  exp_sticky;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_cnt(input logic [2:0] s, output logic [CW-1:0] c, output logic [CW-1:0] e);
        sel = s;
        #1;
        c = correct_cnt;
        e = error_cnt;
    endtask

    // One counted window: clr, enter RUN, ncyc driven cycles, one quiet cycle, leave RUN.
    task automatic run_vec(input vec_t v);
        clr = 1'b1; tick(); clr = 1'b0;
        chk_en = 1'b1; tick();
        for (int i = 0; i < v.ncyc; i++) begin
            wr_en = v.wr; rd_en = v.rd; data_in = v.base + 16'(i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        chk_en = 1'b0;
        tick();
    endtask

    initial begin
        logic [CW-1:0] c, e;
        rst_n = 1'b0; chk_en = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        data_in = '0; sel = 3'd0; bug_full0 = 1'b0;

        //            wr    rd    base      ncyc corr err sticky
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 19, 20, 0, 8'h00}; // idle after reset
        vecs[1] = '{1'b1, 1'b0, 16'h0001,  9, 10, 0, 8'h00}; // fill 1..8 plus one overflow try
        vecs[2] = '{1'b0, 1'b1, 16'h0000,  9, 10, 0, 8'h00}; // drain 1..8 plus one underflow try
        vecs[3] = '{1'b1, 1'b0, 16'h0010,  4,  5, 0, 8'h00}; // hold four entries
        vecs[4] = '{1'b1, 1'b1, 16'h0020, 10, 11, 0, 8'h00}; // simultaneous rd/wr, pointers wrap
        vecs[5] = '{1'b0, 1'b1, 16'h0000,  4,  5, 0, 8'h00}; // drain back to empty

        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("reset_sticky", 32'(err_sticky), 32'h0);
        check("reset_any_err", 32'(any_err), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        read_cnt(SIG_EMPTY, c, e);
        check("reset_correct", 32'(c), 32'h0);
        check("reset_error", 32'(e), 32'h0);

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v]);
            check($sformatf("vec%0d_sticky", v), 32'(err_sticky), 32'(vecs[v].exp_sticky));
            check($sformatf("vec%0d_any_err", v), 32'(any_err), 32'(|vecs[v].exp_sticky));
            for (int s = 0; s < NUM_SIGS; s++) begin
                read_cnt(3'(s), c, e);
                check($sformatf("vec%0d_correct_sel%0d", v, s), 32'(c), 32'(vecs[v].exp_corr));
                check($sformatf("vec%0d_error_sel%0d", v, s), 32'(e), 32'(vecs[v].exp_err));
            end
        end

        // Saturation: 41 counted cycles on a 5-bit counter stop at 31.
        clr = 1'b1; tick(); clr = 1'b0;
        chk_en = 1'b1; tick();
        repeat (41) tick();
        chk_en = 1'b0; tick();
        read_cnt(SIG_EMPTY, c, e);
        check("sat_correct", 32'(c), 32'd31);
        check("sat_error", 32'(e), 32'd0);

        // Fault: observed full stuck at 0 while filling eight entries.
        clr = 1'b1; tick(); clr = 1'b0;
        bug_full0 = 1'b1;
        chk_en = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = 16'h0040 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        check("bug_sticky_before", 32'(err_sticky[SIG_FULL]), 32'h0);
        tick();
        check("bug_sticky_full", 32'(err_sticky), 32'h02);
        check("bug_any_err", 32'(any_err), 32'h1);
        read_cnt(SIG_FULL, c, e);
        check("bug_full_err_first", 32'(e), 32'd1);
`ifdef FIFO_CHK_HALT_EN
        check("bug_halted", 32'(halted), 32'h1);
        tick(); tick(); tick();
        read_cnt(SIG_FULL, c, e);
        check("bug_full_err_frozen", 32'(e), 32'd1);
        check("bug_full_corr_frozen", 32'(c), 32'd8);
        read_cnt(SIG_EMPTY, c, e);
        check("bug_empty_corr_frozen", 32'(c), 32'd9);
`else
        check("bug_halted", 32'(halted), 32'h0);
        tick(); tick(); tick();
        read_cnt(SIG_FULL, c, e);
        check("bug_full_err_counting", 32'(e), 32'd4);
        check("bug_full_corr", 32'(c), 32'd8);
        read_cnt(SIG_EMPTY, c, e);
        check("bug_empty_corr", 32'(c), 32'd12);
`endif
        chk_en = 1'b0; tick();

        // Async reset in the middle of a fill, then clr and a read from empty.
        bug_full0 = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; data_in = 16'h0050 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_sticky", 32'(err_sticky), 32'h0);
        check("midrst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        read_cnt(SIG_FULL, c, e);
        check("midrst_correct", 32'(c), 32'd0);
        check("midrst_error", 32'(e), 32'd0);
        chk_en = 1'b1; tick();
        rd_en = 1'b1; tick();
        rd_en = 1'b0; tick();
        chk_en = 1'b0; tick();
        read_cnt(SIG_UNDERFLOW, c, e);
        check("midrst_underflow_corr", 32'(c), 32'd2);
        check("midrst_underflow_err", 32'(e), 32'd0);
        read_cnt(SIG_EMPTY, c, e);
        check("midrst_empty_corr", 32'(c), 32'd2);
        check("midrst_final_sticky", 32'(err_sticky), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_checker.md
# fifo_checker

Synthesizable, parametrised checker for the team's synchronous FIFO (wr_ack / overflow / underflow / full / empty / almostfull / almostempty / data_out). It sits beside a FIFO instance and passively observes its ports. It runs a cycle-accurate shadow model of the FIFO and compares every DUT output each cycle. Per-signal correct/error counts are kept for readout, so the checks also work in emulation and FPGA builds, not only in simulation.

## Interface
- FIFO_WIDTH, 16, data width of the observed FIFO.
- FIFO_DEPTH, 8, depth of the observed FIFO; must be ≥ 4.
- CNT_W, 16, width of each correct/error counter.
- clk  in  1  observed FIFO clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- chk_en  in  1  enables comparison and counting.
- clr  in  1  synchronous clear of counters, sticky errors and halt.
- wr_en, rd_en  in  1 each  observed FIFO inputs.
- data_in  in  FIFO_WIDTH  observed FIFO write data.
- data_out  in  FIFO_WIDTH  observed FIFO read data.
- wr_ack, overflow, underflow, full, empty, almostfull, almostempty  in  1 each  observed FIFO outputs.
- sel  in  3  signal index for counter readout.
- correct_cnt  out  CNT_W  correct count for signal `sel`; combinational mux.
- error_cnt  out  CNT_W  error count for signal `sel`; combinational mux.
- err_sticky  out  8  per-signal sticky mismatch bits, indexed as in the package.
- any_err  out  1  OR of err_sticky.
- halted  out  1  checker frozen after an error; only meaningful when the halt feature is compiled in.

## Operation
- Reference semantics:
  - A write is accepted when wr_en && !full.
  - A read is accepted when rd_en && !empty.
  - When both are requested and the FIFO is neither full nor empty, both are accepted and the count is unchanged.
  - When full, only the read is accepted. When empty, only the write is accepted.
- Expected outputs from the shadow count:
  - full = (count == FIFO_DEPTH)
  - empty = (count == 0)
  - almostfull = (count == FIFO_DEPTH-1)
  - almostempty = (count == 1)
- Registered expectations, computed in cycle N and compared in cycle N+1:
  - wr_ack = accepted write
  - overflow = wr_en && full
  - underflow = rd_en && empty
  - data_out = the shadow-memory word at the read pointer, only when a read was accepted. Otherwise the previous expected data_out is held.
- Shadow memory and pointers are FIFO_DEPTH entries, with pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits.
- FSM states:
  - ST_IDLE: shadow model tracks, no counting. Enter ST_RUN when chk_en=1.
  - ST_RUN: on each cycle, every signal increments exactly one of its correct/error counters.
  - ST_RUN returns to ST_IDLE when chk_en=0.
  - ST_RUN goes to ST_HALT on a mismatch, with the halt feature only.
  - ST_HALT exits to ST_IDLE only on clr.
- Counters saturate at all-ones. clr zeroes counters and err_sticky but does not disturb the shadow model.
- sel ≥ 8 reads 0 on both counter outputs.

## Timing
- Reset values:
  - all counters 0, err_sticky 0, any_err 0, halted 0
  - state ST_IDLE, shadow count 0, pointers 0
  - all registered expectations 0
- Combinational flags are compared in the same cycle against the current shadow count.
- Registered outputs are compared one cycle after the causing inputs.
- First cycle after rst_n deasserts: expected empty=1 and all registered expectations 0.
- err_sticky and the counters update on the clock edge after the mismatch is sampled. any_err follows err_sticky combinationally.
- Reset asserted mid-operation clears everything immediately. The DUT must likewise reset to empty, otherwise errors are counted.
- Wrap: a pointer at FIFO_DEPTH-1 advances to 0.

## Configuration
- FIFO_CHK_HALT_EN defined: the first mismatch in ST_RUN enters ST_HALT. halted=1, and the shadow model and counters freeze on the offending cycle's values.
- FIFO_CHK_HALT_EN undefined: ST_HALT is unreachable and halted is tied to 0. Checking continues, and the shadow model keeps following its own prediction, not the DUT.

## Structure
- fifo_chk_pkg (shared package) holds:
  - the signal-index enum: SIG_WR_ACK=0, SIG_FULL, SIG_EMPTY, SIG_ALMOSTFULL, SIG_ALMOSTEMPTY, SIG_OVERFLOW, SIG_UNDERFLOW, SIG_DATA_OUT=7
  - NUM_SIGS=8
  - the FSM state enum
- Sub-module fifo_ref_model contains the shadow memory, pointers, count and registered expectations. The top level holds the FSM, compare logic, counters and readout mux.

## Test plan
All scenarios use FIFO_DEPTH=8 and FIFO_WIDTH=16, driven against a correct FIFO unless stated.
- Reset, then 20 idle cycles with chk_en=1 → error_cnt=0 for all sel; correct_cnt[SIG_EMPTY]=20.
- 8 writes 0x0001..0x0008, then 1 more write → full=1 expected; overflow error count 0; wr_ack correct on all 9 cycles.
- 8 reads after a fill → data_out matches 0x0001..0x0008 in order. A 9th read expects underflow=1 next cycle.
- Simultaneous wr_en/rd_en with 4 entries held for 10 cycles (pointers wrap) → count stays 4, zero errors.
- Inject a DUT bug with full stuck at 0 → err_sticky[SIG_FULL] set the cycle after the 8th write.
  - With FIFO_CHK_HALT_EN: halted=1 and counters frozen.
  - Without FIFO_CHK_HALT_EN: error_cnt[SIG_FULL] keeps incrementing.
- Async reset asserted mid-fill (5 entries), then clr pulsed → all counters 0 and shadow count 0. A following read expects underflow=1.
